// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction memory loader and the fetch stage.
package instr_mem_loader_pkg;

  // Loader FSM state encoding (3 bits).
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLenHi  = 3'd1,
    StLenLo  = 3'd2,
    StDataHi = 3'd3,
    StDataLo = 3'd4,
    StWrite  = 3'd5,
    StDone   = 3'd6
  } state_t;

  // Stream header length in bytes (LEN_HI, LEN_LO).
  localparam int unsigned HDR_BYTES  = 2;
  // Instruction word size in bytes; also the fetch PC increment.
  localparam int unsigned WORD_BYTES = 2;

endpackage

// File: rtl/instr_mem_loader_if.sv
// Byte-stream handshake bundle between the host byte source and the loader.
interface instr_mem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/instr_mem_loader_byte_pair_assembler.sv
// Captures a high byte then a low byte into a 16-bit word; word_valid_o pulses the
// cycle after the low byte is captured.
module instr_mem_loader_byte_pair_assembler (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  input  logic [7:0]  byte_i,
  output logic [15:0] word_o,
  output logic        word_valid_o
);

  logic [15:0] word_q;
  logic        valid_q;

  // Byte capture registers and the one-cycle valid strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= lo_we_i;
      if (hi_we_i) word_q[15:8] <= byte_i;
      if (lo_we_i) word_q[7:0]  <= byte_i;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = valid_q;

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed byte-stream program image into the 16-bit instruction memory
// and holds the CPU in reset while the load runs.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter int unsigned       DEPTH_WORDS = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  instr_mem_loader_if.slave   in_bus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                cpu_hold
);

  localparam int unsigned CNT_W = $clog2(DEPTH_WORDS + 1);

  state_t            state_q, state_d;
  logic [7:0]        len_hi_q, len_hi_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              err_q, err_d;
  logic              hs;
  logic              hi_we, lo_we;
  logic [15:0]       n_full;

  assign hs     = in_bus.in_valid & in_bus.in_ready;
  assign n_full = {len_hi_q, in_bus.in_data};

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Length, word counter, address and error registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_hi_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= BASE_ADDR;
      err_q    <= 1'b0;
    end else begin
      len_hi_q <= len_hi_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
    end
  end

  // Next-state, counter updates and byte-capture strobes.
  always_comb begin
    state_d          = state_q;
    len_hi_d         = len_hi_q;
    len_d            = len_q;
    cnt_d            = cnt_q;
    addr_d           = addr_q;
    err_d            = err_q;
    hi_we            = 1'b0;
    lo_we            = 1'b0;
    in_bus.in_ready  = 1'b0;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StLenHi;
          addr_d  = BASE_ADDR;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLenHi: begin
        in_bus.in_ready = 1'b1;
        if (hs) begin
          len_hi_d = in_bus.in_data;
          state_d  = StLenLo;
        end
      end
      StLenLo: begin
        in_bus.in_ready = 1'b1;
        if (hs) begin
          if (n_full == 16'd0) begin
            state_d = StDone;
          end else if (32'(n_full) > DEPTH_WORDS) begin
            // Oversized image: finish without consuming the rest of the stream.
            state_d = StDone;
            err_d   = 1'b1;
          end else begin
            len_d   = CNT_W'(n_full);
            state_d = StDataHi;
          end
        end
      end
      StDataHi: begin
        in_bus.in_ready = 1'b1;
        hi_we           = hs;
        if (hs) state_d = StDataLo;
      end
      StDataLo: begin
        in_bus.in_ready = 1'b1;
        lo_we           = hs;
        if (hs) state_d = StWrite;
      end
      StWrite: begin
        addr_d  = addr_q + ADDR_W'(WORD_BYTES);
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_d < len_q) ? StDataHi : StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // mem_we coincides with StWrite: the assembler strobe follows the low-byte handshake.
  instr_mem_loader_byte_pair_assembler u_assembler (
    .clk_i        (clk),
    .reset_i      (reset),
    .hi_we_i      (hi_we),
    .lo_we_i      (lo_we),
    .byte_i       (in_bus.in_data),
    .word_o       (mem_wdata),
    .word_valid_o (mem_we)
  );

  assign mem_addr = addr_q;
  assign busy     = (state_q == StLenHi)  || (state_q == StLenLo) ||
                    (state_q == StDataHi) || (state_q == StDataLo) ||
                    (state_q == StWrite);
  assign done     = (state_q == StDone);
  assign error    = err_q;
  assign cpu_hold = busy;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: one default instance and one with a 4-word depth
// based at 0xFFFE, each feeding an instruction memory model.
module tb_instr_mem_loader;
  import instr_mem_loader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start_a, start_b;
  instr_mem_loader_if ifa ();
  instr_mem_loader_if ifb ();

  logic        we_a, busy_a, done_a, err_a, hold_a;
  logic [15:0] addr_a, wdata_a;
  logic        we_b, busy_b, done_b, err_b, hold_b;
  logic [15:0] addr_b, wdata_b;

  instr_mem_loader u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .start     (start_a),
    .in_bus    (ifa),
    .mem_we    (we_a),
    .mem_addr  (addr_a),
    .mem_wdata (wdata_a),
    .busy      (busy_a),
    .done      (done_a),
    .error     (err_a),
    .cpu_hold  (hold_a)
  );

  instr_mem_loader #(
    .ADDR_W      (16),
    .DEPTH_WORDS (4),
    .BASE_ADDR   (16'hFFFE)
  ) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .start     (start_b),
    .in_bus    (ifb),
    .mem_we    (we_b),
    .mem_addr  (addr_b),
    .mem_wdata (wdata_b),
    .busy      (busy_b),
    .done      (done_b),
    .error     (err_b),
    .cpu_hold  (hold_b)
  );

  int checks = 0;
  int errors = 0;

  // Instruction memory models and write logs.
  logic [15:0] mem_a [logic [15:0]];
  logic [15:0] mem_b [logic [15:0]];
  int          wr_a = 0;
  int          wr_b = 0;
  logic [15:0] wb_addr [$];

  always @(negedge clk) begin
    if (we_a) begin
      mem_a[addr_a] = wdata_a;
      wr_a++;
    end
    if (we_b) begin
      mem_b[addr_b] = wdata_b;
      wr_b++;
      wb_addr.push_back(addr_b);
    end
  end

  // Present one byte after gap idle cycles; returns on the negedge after the handshake.
  task automatic send(input int sel, input logic [7:0] b, input int gap);
    int t;
    if (sel == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    if (sel == 0) begin ifa.in_valid = 1'b1; ifa.in_data = b; end
    else          begin ifb.in_valid = 1'b1; ifb.in_data = b; end
    t = 0;
    while (((sel == 0) ? !ifa.in_ready : !ifb.in_ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 100) begin
      errors++;
      $display("FAIL send_timeout: dut %0d in_ready stayed 0 for %0d cycles, required 1", sel, t);
    end
    @(negedge clk);
    if (sel == 0) ifa.in_valid = 1'b0; else ifb.in_valid = 1'b0;
  endtask

  task automatic start_pulse(input int sel);
    @(negedge clk);
    if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.in_data = '0;
    ifb.in_valid = 1'b0; ifb.in_data = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.in_ready, we_a, busy_a, done_a, err_a, hold_a} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl_a: got %b, required 000000",
               {ifa.in_ready, we_a, busy_a, done_a, err_a, hold_a});
    end
    checks++;
    if (addr_a !== 16'h0000 || wdata_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_bus_a: addr=%h wdata=%h, required 0000/0000", addr_a, wdata_a);
    end
    checks++;
    if ({ifb.in_ready, we_b, busy_b, done_b, err_b, hold_b} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl_b: got %b, required 000000",
               {ifb.in_ready, we_b, busy_b, done_b, err_b, hold_b});
    end
    checks++;
    if (addr_b !== 16'hFFFE) begin
      errors++;
      $display("FAIL reset_addr_b: got %h, required fffe", addr_b);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || ifa.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b ready=%b, required 0/0", busy_a, ifa.in_ready);
    end
  endtask

  task automatic test_basic;
    logic [7:0]  img [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
    logic [15:0] exp [3] = '{16'h1234, 16'hABCD, 16'h0001};
    int w0;
    w0 = wr_a;
    start_pulse(0);
    checks++;
    if ({busy_a, hold_a, ifa.in_ready} !== 3'b111) begin
      errors++;
      $display("FAIL basic_start: busy/hold/ready=%b, required 111", {busy_a, hold_a, ifa.in_ready});
    end
    for (int i = 0; i < 8; i++) send(0, img[i], $urandom_range(0, 2));
    checks++;
    if (we_a !== 1'b1 || addr_a !== 16'h0004 || wdata_a !== 16'h0001 || done_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_last_write: we=%b addr=%h wdata=%h done=%b, required 1/0004/0001/0",
               we_a, addr_a, wdata_a, done_a);
    end
    @(negedge clk);
    checks++;
    if ({done_a, err_a, busy_a, hold_a, ifa.in_ready} !== 5'b10000) begin
      errors++;
      $display("FAIL basic_done: done/err/busy/hold/ready=%b, required 10000",
               {done_a, err_a, busy_a, hold_a, ifa.in_ready});
    end
    checks++;
    if (wr_a - w0 !== 3) begin
      errors++;
      $display("FAIL basic_wr_count: got %0d, required 3", wr_a - w0);
    end
    for (int pc = 0; pc < 6; pc += WORD_BYTES) begin
      checks++;
      if (mem_a[16'(pc)] !== exp[pc / 2]) begin
        errors++;
        $display("FAIL basic_fetch: pc=%0d got %h, required %h", pc, mem_a[16'(pc)], exp[pc / 2]);
      end
    end
  endtask

  task automatic test_zero_len;
    int w0;
    w0 = wr_a;
    start_pulse(0);
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_start_clears_done: got %b, required 0", done_a);
    end
    send(0, 8'h00, 0);
    checks++;
    if (done_a !== 1'b0) begin
      errors++;
      $display("FAIL zero_after_hi: done=%b, required 0", done_a);
    end
    send(0, 8'h00, 0);
    checks++;
    if ({done_a, err_a, ifa.in_ready} !== 3'b100) begin
      errors++;
      $display("FAIL zero_done: done/err/ready=%b, required 100", {done_a, err_a, ifa.in_ready});
    end
    @(negedge clk);
    checks++;
    if (wr_a != w0) begin
      errors++;
      $display("FAIL zero_no_write: got %0d writes, required 0", wr_a - w0);
    end
  endtask

  task automatic test_reject;
    int w0;
    int rdy_seen;
    w0 = wr_b;
    start_pulse(1);
    send(1, 8'h00, 1);
    send(1, 8'h05, 0);
    checks++;
    if ({done_b, err_b, ifb.in_ready, busy_b} !== 4'b1100) begin
      errors++;
      $display("FAIL reject_done: done/err/ready/busy=%b, required 1100",
               {done_b, err_b, ifb.in_ready, busy_b});
    end
    rdy_seen = 0;
    ifb.in_valid = 1'b1; ifb.in_data = 8'h11;
    repeat (4) begin
      @(negedge clk);
      if (ifb.in_ready !== 1'b0) rdy_seen++;
    end
    ifb.in_valid = 1'b0;
    checks++;
    if (rdy_seen != 0) begin
      errors++;
      $display("FAIL reject_ready: in_ready high %0d cycles, required 0", rdy_seen);
    end
    checks++;
    if (wr_b != w0 || err_b !== 1'b1) begin
      errors++;
      $display("FAIL reject_no_write: writes=%0d err=%b, required 0/1", wr_b - w0, err_b);
    end
  endtask

  task automatic test_wrap;
    int w0;
    w0 = wr_b;
    wb_addr.delete();
    start_pulse(1);
    checks++;
    if (err_b !== 1'b0 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap_start_clears: err=%b done=%b, required 0/0", err_b, done_b);
    end
    send(1, 8'h00, 0);
    send(1, 8'h02, 1);
    send(1, 8'hAA, 0);
    send(1, 8'h55, 2);
    checks++;
    if (we_b !== 1'b1 || addr_b !== 16'hFFFE || wdata_b !== 16'hAA55) begin
      errors++;
      $display("FAIL wrap_first: we=%b addr=%h wdata=%h, required 1/fffe/aa55", we_b, addr_b, wdata_b);
    end
    start_pulse(1);
    checks++;
    if (busy_b !== 1'b1 || done_b !== 1'b0) begin
      errors++;
      $display("FAIL wrap_start_ignored: busy=%b done=%b, required 1/0", busy_b, done_b);
    end
    send(1, 8'h66, 0);
    send(1, 8'h77, 0);
    @(negedge clk);
    checks++;
    if ({done_b, err_b} !== 2'b10 || addr_b !== 16'h0002) begin
      errors++;
      $display("FAIL wrap_done: done/err=%b addr=%h, required 10/0002", {done_b, err_b}, addr_b);
    end
    checks++;
    if (wr_b - w0 != 2 || wb_addr.size() != 2) begin
      errors++;
      $display("FAIL wrap_count: got %0d writes, required 2", wr_b - w0);
    end else begin
      checks++;
      if (wb_addr[0] !== 16'hFFFE || wb_addr[1] !== 16'h0000 || mem_b[16'h0000] !== 16'h6677) begin
        errors++;
        $display("FAIL wrap_addrs: %h %h data0=%h, required fffe 0000 data0=6677",
                 wb_addr[0], wb_addr[1], mem_b[16'h0000]);
      end
    end
  endtask

  task automatic test_full_depth;
    logic [7:0] img [10] = '{8'h00, 8'h04, 8'h01, 8'h01, 8'h02, 8'h02,
                             8'h03, 8'h03, 8'h04, 8'h04};
    int w0;
    w0 = wr_b;
    wb_addr.delete();
    start_pulse(1);
    for (int i = 0; i < 10; i++) send(1, img[i], $urandom_range(0, 1));
    @(negedge clk);
    checks++;
    if ({done_b, err_b} !== 2'b10 || wr_b - w0 != 4) begin
      errors++;
      $display("FAIL full_depth: done/err=%b writes=%0d, required 10/4", {done_b, err_b}, wr_b - w0);
    end
    checks++;
    if (wb_addr.size() != 4 || wb_addr[3] !== 16'h0004 || mem_b[16'h0004] !== 16'h0404) begin
      errors++;
      $display("FAIL full_depth_last: last addr/data wrong, data=%h, required 0004/0404",
               mem_b[16'h0004]);
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] img [8] = '{8'h00, 8'h03, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h5A, 8'hA5};
    int w0;
    w0 = wr_a;
    start_pulse(0);
    send(0, 8'h00, 0);
    send(0, 8'h03, 0);
    send(0, 8'h11, 1);
    send(0, 8'h22, 0);
    send(0, 8'h33, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({ifa.in_ready, we_a, busy_a, done_a, err_a, hold_a} !== 6'b0 ||
        addr_a !== 16'h0000 || wdata_a !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_outputs: ctrl=%b addr=%h wdata=%h, required 000000/0000/0000",
               {ifa.in_ready, we_a, busy_a, done_a, err_a, hold_a}, addr_a, wdata_a);
    end
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (wr_a - w0 != 1 || mem_a[16'h0000] !== 16'h1122 || mem_a[16'h0002] !== 16'hABCD) begin
      errors++;
      $display("FAIL reset_mid_partial: writes=%0d m0=%h m2=%h, required 1/1122/abcd",
               wr_a - w0, mem_a[16'h0000], mem_a[16'h0002]);
    end
    start_pulse(0);
    for (int i = 0; i < 8; i++) send(0, img[i], $urandom_range(0, 2));
    @(negedge clk);
    checks++;
    if ({done_a, err_a} !== 2'b10 || wr_a - w0 != 4) begin
      errors++;
      $display("FAIL reload_done: done/err=%b writes=%0d, required 10/4", {done_a, err_a}, wr_a - w0);
    end
    checks++;
    if (mem_a[16'h0000] !== 16'hDEAD || mem_a[16'h0002] !== 16'hBEEF ||
        mem_a[16'h0004] !== 16'h5AA5) begin
      errors++;
      $display("FAIL reload_data: %h %h %h, required dead beef 5aa5",
               mem_a[16'h0000], mem_a[16'h0002], mem_a[16'h0004]);
    end
  endtask

  task automatic test_stall;
    int w0;
    int bad;
    w0 = wr_a;
    start_pulse(0);
    send(0, 8'h00, 0);
    send(0, 8'h01, 0);
    send(0, 8'hC3, 0);
    bad = 0;
    // Previous image ended with 0x5AA5, so the low byte still holds 0xA5.
    repeat (5) begin
      if (wdata_a !== 16'hC3A5 || addr_a !== 16'h0000 || we_a !== 1'b0 || ifa.in_ready !== 1'b1)
        bad++;
      @(negedge clk);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable: %0d bad cycles, required 0 (wdata=%h addr=%h)",
               bad, wdata_a, addr_a);
    end
    send(0, 8'h3C, 0);
    checks++;
    if (we_a !== 1'b1 || wdata_a !== 16'hC33C || addr_a !== 16'h0000) begin
      errors++;
      $display("FAIL stall_write: we=%b wdata=%h addr=%h, required 1/c33c/0000",
               we_a, wdata_a, addr_a);
    end
    @(negedge clk);
    checks++;
    if (we_a !== 1'b0 || done_a !== 1'b1 || wr_a - w0 != 1) begin
      errors++;
      $display("FAIL stall_single_we: we=%b done=%b writes=%0d, required 0/1/1",
               we_a, done_a, wr_a - w0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_reject();
    test_wrap();
    test_full_depth();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
